// File: rtl/bus_memory_if.sv
// CPU-side word bus for bus_memory: address, write data, request strobe, direction and read data.
// CS marks a valid request and there is no ready: every CS=1 cycle is accepted at the rising edge, and a read returns on Data_BUS_READ one cycle later.
interface bus_memory_if;
    logic [31:0] ADDR;
    logic [31:0] Data_BUS_WRITE;
    logic [31:0] Data_BUS_READ;
    logic        CS;
    logic        WR_RD;

    modport master (
        output ADDR,
        output Data_BUS_WRITE,
        output CS,
        output WR_RD,
        input  Data_BUS_READ
    );

    modport slave (
        input  ADDR,
        input  Data_BUS_WRITE,
        input  CS,
        input  WR_RD,
        output Data_BUS_READ
    );
endinterface

// File: rtl/bus_memory.sv
// Single-cycle word RAM plus a 3-register I/O window (IO_OUT, CYCLES, STATUS) on a CS/WR_RD bus.
// Out-of-range accesses read as zero, drop writes and latch a sticky BUS_ERR.
module bus_memory #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] IO_BASE     = 32'h0000_8000
) (
    input  logic              CLK,
    input  logic              RST,
    bus_memory_if.slave       bus,
    output logic [31:0]       IO_OUT,
    output logic              BUS_ERR
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [31:0]   ram_q [DEPTH_WORDS];
    logic [31:0]   rd_data_q, rd_data_d;
    logic [31:0]   io_out_q, io_out_d;
    logic [31:0]   cycles_q, cycles_d;
    logic          bus_err_q, bus_err_d;
    logic          ram_we;
    logic          ram_hit, io_hit;
    logic [AW-1:0] word_idx;
    logic [1:0]    io_off;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.ADDR[1:0];
    assign word_idx = bus.ADDR[AW+1:2];
    assign io_off   = bus.ADDR[3:2];
    assign ram_hit  = (bus.ADDR[31:AW+2] == '0);
    // Offset 0xC sits inside the 16-byte window but is not a register.
    assign io_hit   = (bus.ADDR[31:4] == IO_BASE[31:4]) && (io_off != 2'd3);

    always_comb begin
        rd_data_d = rd_data_q;
        io_out_d  = io_out_q;
        cycles_d  = cycles_q + 32'd1;
        bus_err_d = bus_err_q;
        ram_we    = 1'b0;
        if (bus.CS) begin
            if (ram_hit) begin
                if (bus.WR_RD) ram_we = 1'b1;
                else           rd_data_d = ram_q[word_idx];
            end else if (io_hit) begin
                case (io_off)
                    2'd0: begin
                        if (bus.WR_RD) io_out_d = bus.Data_BUS_WRITE;
                        else           rd_data_d = io_out_q;
                    end
                    2'd1: begin
                        // Reads see the count before this edge's increment.
                        if (bus.WR_RD) cycles_d = bus.Data_BUS_WRITE;
                        else           rd_data_d = cycles_q;
                    end
                    default: begin
                        if (bus.WR_RD) bus_err_d = 1'b0;
                        else           rd_data_d = {31'b0, bus_err_q};
                    end
                endcase
            end else begin
                bus_err_d = 1'b1;
                if (!bus.WR_RD) rd_data_d = 32'h0000_0000;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rd_data_q <= 32'h0000_0000;
            io_out_q  <= 32'h0000_0000;
            cycles_q  <= 32'h0000_0000;
            bus_err_q <= 1'b0;
        end else begin
            rd_data_q <= rd_data_d;
            io_out_q  <= io_out_d;
            cycles_q  <= cycles_d;
            bus_err_q <= bus_err_d;
        end
    end

    // RAM is never cleared; RST only blocks writes sampled while it is low.
    always_ff @(posedge CLK) begin
        if (RST && ram_we) ram_q[word_idx] <= bus.Data_BUS_WRITE;
    end

    assign bus.Data_BUS_READ = rd_data_q;
    assign IO_OUT            = io_out_q;
    assign BUS_ERR           = bus_err_q;
endmodule

// File: tb/tb_bus_memory.sv
// Directed bench for bus_memory: a behavioural model checked every negedge plus literal pins.
module tb_bus_memory;
    localparam int unsigned DEPTH   = 256;
    localparam logic [31:0] IO_BASE = 32'h0000_8000;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IO_OUT;
    logic        BUS_ERR;

    bus_memory_if bus ();

    bus_memory #(.DEPTH_WORDS(DEPTH), .IO_BASE(IO_BASE)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .bus    (bus),
        .IO_OUT (IO_OUT),
        .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]     m_ram [int];
    logic [31:0]     m_rd = 32'h0;
    bit              m_rd_known = 1'b1;
    logic [31:0]     m_io = 32'h0;
    bit              m_err = 1'b0;
    longint unsigned m_edges = 0;
    logic [31:0]     m_cyc_base = 32'h0;
    longint unsigned m_cyc_edge = 0;

    // CYCLES as seen at edge number m_edges: the last loaded value plus elapsed edges.
    function automatic logic [31:0] m_cycles();
        return m_cyc_base + 32'(m_edges - m_cyc_edge);
    endfunction

    always @(posedge CLK or negedge RST) begin : model
        logic [31:0] a;
        int unsigned off;
        int          key;
        if (!RST) begin
            m_rd       = 32'h0;
            m_rd_known = 1'b1;
            m_io       = 32'h0;
            m_err      = 1'b0;
            m_edges    = 0;
            m_cyc_base = 32'h0;
            m_cyc_edge = 0;
        end else begin
            a = bus.ADDR;
            if (bus.CS) begin
                if (a < 32'(4 * DEPTH)) begin
                    key = int'(a >> 2);
                    if (bus.WR_RD) m_ram[key] = bus.Data_BUS_WRITE;
                    else if (m_ram.exists(key)) begin
                        m_rd = m_ram[key];
                        m_rd_known = 1'b1;
                    end else m_rd_known = 1'b0;
                end else if (a >= IO_BASE && a < IO_BASE + 32'd12) begin
                    off = (a - IO_BASE) >> 2;
                    if (off == 0) begin
                        if (bus.WR_RD) m_io = bus.Data_BUS_WRITE;
                        else m_rd = m_io;
                    end else if (off == 1) begin
                        if (bus.WR_RD) begin
                            m_cyc_base = bus.Data_BUS_WRITE;
                            m_cyc_edge = m_edges + 1;
                        end else m_rd = m_cycles();
                    end else begin
                        if (bus.WR_RD) m_err = 1'b0;
                        else m_rd = {31'b0, m_err};
                    end
                    if (!bus.WR_RD) m_rd_known = 1'b1;
                end else begin
                    m_err = 1'b1;
                    if (!bus.WR_RD) begin
                        m_rd = 32'h0;
                        m_rd_known = 1'b1;
                    end
                end
            end
            m_edges++;
        end
    end

    always @(negedge CLK) begin
        if (m_rd_known) check("model_rd", bus.Data_BUS_READ, m_rd);
        check("model_io_out", IO_OUT, m_io);
        check("model_bus_err", {31'b0, BUS_ERR}, {31'b0, m_err});
    end

    // ---------------- drivers ----------------
    task automatic drive(input bit cs, input bit wr, input logic [31:0] a, input logic [31:0] d);
        @(posedge CLK);
        #1;
        bus.CS             = cs;
        bus.WR_RD          = wr;
        bus.ADDR           = a;
        bus.Data_BUS_WRITE = d;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d);
    endtask

    task automatic do_read(input logic [31:0] a);
        drive(1'b1, 1'b0, a, 32'h0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        logic [31:0] v1, v2;
        RST = 1'b0;
        bus.CS = 1'b0;
        bus.WR_RD = 1'b0;
        bus.ADDR = 32'h0;
        bus.Data_BUS_WRITE = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_rd", bus.Data_BUS_READ, 32'h0);
        check("reset_io", IO_OUT, 32'h0);
        check("reset_err", {31'b0, BUS_ERR}, 32'h0);
        #3 RST = 1'b1;

        // write then read-after-write
        do_write(32'h10, 32'hDEAD_BEEF);
        do_read(32'h10);
        idle();
        check("raw_rd", bus.Data_BUS_READ, 32'hDEAD_BEEF);
        check("raw_err", {31'b0, BUS_ERR}, 32'h0);

        // back-to-back writes and reads, then hold
        do_write(32'h0, 32'd1);
        do_write(32'h4, 32'd2);
        do_write(32'h3FC, 32'd3);
        do_read(32'h3FC);
        do_read(32'h0);
        check("b2b_rd_3fc", bus.Data_BUS_READ, 32'd3);
        do_read(32'h4);
        check("b2b_rd_0", bus.Data_BUS_READ, 32'd1);
        idle();
        check("b2b_rd_4", bus.Data_BUS_READ, 32'd2);
        do_write(32'h8, 32'd77);
        idle();
        idle();
        check("hold_rd", bus.Data_BUS_READ, 32'd2);

        // IO_OUT register
        do_write(IO_BASE, 32'hA5A5_0001);
        idle();
        check("io_out_wr", IO_OUT, 32'hA5A5_0001);
        do_read(IO_BASE);
        idle();
        check("io_out_rd", bus.Data_BUS_READ, 32'hA5A5_0001);

        // set BUS_ERR, then asynchronous reset mid-cycle
        do_write(32'h4000, 32'h1234_5678);
        idle();
        check("miss_wr_err", {31'b0, BUS_ERR}, 32'h1);
        #2 RST = 1'b0;
        #1;
        check("async_io", IO_OUT, 32'h0);
        check("async_rd", bus.Data_BUS_READ, 32'h0);
        check("async_err", {31'b0, BUS_ERR}, 32'h0);
        bus.CS = 1'b1;
        bus.WR_RD = 1'b1;
        bus.ADDR = 32'h10;
        bus.Data_BUS_WRITE = 32'h0;
        repeat (2) @(posedge CLK);
        #1;
        bus.WR_RD = 1'b0;
        bus.ADDR = IO_BASE + 32'h4;
        #2 RST = 1'b1;
        do_read(32'h10);
        check("cycles_after_reset", bus.Data_BUS_READ, 32'h0);
        idle();
        check("ram_persist", bus.Data_BUS_READ, 32'hDEAD_BEEF);

        // CYCLES wrap and rate
        do_write(IO_BASE + 32'h4, 32'hFFFF_FFFE);
        idle();
        idle();
        do_read(IO_BASE + 32'h4);
        idle();
        check("cycles_wrap", bus.Data_BUS_READ, 32'h0);
        do_read(IO_BASE + 32'h4);
        idle();
        v1 = bus.Data_BUS_READ;
        do_read(IO_BASE + 32'h4);
        idle();
        v2 = bus.Data_BUS_READ;
        check("cycles_v1", v1, 32'd2);
        check("cycles_delta", v2 - v1, 32'd2);

        // miss, STATUS read/clear, miss write leaves aliased word 0 alone
        do_read(32'h0000_4000);
        idle();
        check("miss_rd", bus.Data_BUS_READ, 32'h0);
        check("miss_rd_err", {31'b0, BUS_ERR}, 32'h1);
        do_read(IO_BASE + 32'h8);
        idle();
        check("status_rd", bus.Data_BUS_READ, 32'h1);
        do_write(IO_BASE + 32'h8, 32'h0);
        idle();
        check("status_clr", {31'b0, BUS_ERR}, 32'h0);
        do_write(32'h0000_4000, 32'hFFFF_FFFF);
        do_read(32'h0);
        idle();
        check("miss_wr_word0", bus.Data_BUS_READ, 32'd1);
        check("miss_wr_err2", {31'b0, BUS_ERR}, 32'h1);

        // boundaries: first address past RAM and IO offset 0xC
        do_write(IO_BASE + 32'h8, 32'h0);
        do_read(32'h400);
        idle();
        check("ram_end_miss_rd", bus.Data_BUS_READ, 32'h0);
        check("ram_end_miss_err", {31'b0, BUS_ERR}, 32'h1);
        do_read(32'h3FC);
        do_write(IO_BASE + 32'h8, 32'h0);
        do_read(IO_BASE + 32'hC);
        idle();
        check("io_c_rd", bus.Data_BUS_READ, 32'h0);
        check("io_c_err", {31'b0, BUS_ERR}, 32'h1);

        idle();
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_memory.md
BUS_MEMORY -- requirements
Module: bus_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit RAM words; power of two, 2..4096.
REQ-002 Parameter IO_BASE, default 32'h0000_8000, byte address of the 3-word I/O window; 16-byte aligned, above RAM range.
REQ-003 CLK  input  1  system clock; all state changes on its rising edge.
REQ-004 RST  input  1  asynchronous, active-low reset.
REQ-005 ADDR  input  32  byte address from the CPU; ADDR[1:0] ignored (word accesses only).
REQ-006 Data_BUS_WRITE  input  32  write data from the CPU.
REQ-007 Data_BUS_READ  output  32  registered read data to the CPU.
REQ-008 CS  input  1  access request, active high, sampled each rising edge.
REQ-009 WR_RD  input  1  1 = write, 0 = read; meaningful only when CS=1.
REQ-010 IO_OUT  output  32  memory-mapped output register.
REQ-011 BUS_ERR  output  1  sticky flag; an out-of-range access has occurred.

Function
REQ-012 Address decode per sampled access: RAM hit if ADDR < 4*DEPTH_WORDS; IO hit if ADDR[31:4]==IO_BASE[31:4] and ADDR[3:2] in {0,1,2}; anything else is a miss.
REQ-013 RAM word index SHALL be ADDR[log2(DEPTH_WORDS)+1:2].
REQ-014 Write (CS=1, WR_RD=1) to RAM SHALL update the word at the rising edge where it is sampled; no wait states.
REQ-015 Read (CS=1, WR_RD=0) SHALL present data on Data_BUS_READ after that rising edge, i.e. 1-cycle latency, held until the next read edge.
REQ-016 Data_BUS_READ SHALL hold its last value on cycles with CS=0 or with a write.
REQ-017 Read in the cycle after a write to the same address SHALL return the newly written data.
REQ-018 IO offset 0x0 (IO_OUT): write loads IO_OUT; read returns IO_OUT.
REQ-019 IO offset 0x4 (CYCLES): free-running 32-bit counter, +1 every cycle out of reset, wraps 32'hFFFF_FFFF -> 0; read returns the value before the sampling edge's increment; writes load the written value, counting resumes from it the next cycle.
REQ-020 IO offset 0x8 (STATUS): read returns {31'b0, BUS_ERR}; any write clears BUS_ERR.
REQ-021 Miss access: write SHALL be discarded, read SHALL return 32'h0000_0000, and BUS_ERR SHALL set at that edge.
REQ-022 IO offset 0xC SHALL be treated as a miss.
REQ-023 Simultaneous set/clear of BUS_ERR cannot occur (one access per cycle); a STATUS write always clears.
REQ-024 No combinational path from any input to any output.

Reset
REQ-025 RST low SHALL immediately force Data_BUS_READ=0, IO_OUT=0, BUS_ERR=0, CYCLES=0, independent of CLK.
REQ-026 RAM contents SHALL NOT be reset; they persist across reset and are undefined after power-up.
REQ-027 An access sampled while RST is low SHALL have no effect; the first access honoured is at the first rising edge with RST high.
REQ-028 Reset deasserted mid-burst: no partial write; CYCLES reads 0 at the first edge after release.

Verification
REQ-029 Write 32'hDEADBEEF to 0x10, then read 0x10 next cycle -> Data_BUS_READ=32'hDEADBEEF one cycle after the read edge; BUS_ERR=0.
REQ-030 Back-to-back writes 0x0=1, 0x4=2, 0x3FC=3 (DEPTH 256), then reads 0x3FC, 0x0, 0x4 -> 3, 1, 2 on consecutive cycles; CS=0 afterwards -> output holds 2.
REQ-031 Write IO_BASE+0 = 32'hA5A5_0001 -> IO_OUT=32'hA5A5_0001 after that edge; read IO_BASE+0 returns same.
REQ-032 Write CYCLES=32'hFFFF_FFFE, idle 2 cycles, read CYCLES -> 0 (wrap confirmed); reads two cycles apart differ by 2.
REQ-033 Read 0x0000_4000 -> Data_BUS_READ=0, BUS_ERR=1; read STATUS -> 1; write STATUS -> BUS_ERR=0; write to miss does not alter RAM word 0.
REQ-034 Pull RST low asynchronously mid-cycle after REQ-031 -> IO_OUT, Data_BUS_READ, BUS_ERR=0 before next edge; after release, read of 0x10 still returns 32'hDEADBEEF.
